pll_lock_sequencer: RTL and testbench

//  Sequences the 200 MHz core PLL after power-up and after loss of lock, in the refclk domain.
//  - Drives the PLL reset, waits for a debounced lock and releases the system reset.
//  - Retries on lock timeout or lock drop, and flags a hard failure after too many retries.
//  - Sits between the board reset and the PLL wrapper's rst/locked pins.

---
 rtl/pll_lock_sequencer.sv | 156 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings the core PLL out of reset, waits for a debounced
// lock and then releases the system reset. It retries when lock does not arrive
// or drops before it is stable, and latches a failure after too many attempts.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lost_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [3:0]       retry_reg, retry_next;
  logic [7:0]       lost_reg, lost_next;
  logic [1:0]       sync_reg;
  logic             lk;
  logic [3:0]       retry_inc;
  logic             pll_rst_reg, sys_rst_reg, ready_reg, fail_reg;
  logic             pll_rst_next, sys_rst_next, ready_next, fail_next;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], pll_locked_i};
  end

  assign lk        = sync_reg[1];
  assign retry_inc = retry_reg + 4'd1;

  // Next-state, timer, counters and output decode; restart_i overrides all events.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    retry_next = retry_reg;
    lost_next  = lost_reg;
    if (restart_i) begin
      state_next = S_RST;
      timer_next = '0;
      retry_next = 4'd0;
    end else begin
      case (state_reg)
        S_RST: begin
          if (timer_reg == RST_LAST) begin
            state_next = S_WAIT;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        S_WAIT: begin
          if (lk) begin
            state_next = S_STABLE;
            timer_next = '0;
          end else if (timer_reg == TIMEOUT_LAST) begin
            retry_next = retry_inc;
            state_next = (int'(retry_inc) >= MAX_RETRY) ? S_FAIL : S_RST;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk) begin
            retry_next = retry_inc;
            state_next = (int'(retry_inc) >= MAX_RETRY) ? S_FAIL : S_RST;
            timer_next = '0;
          end else if (timer_reg == STABLE_LAST) begin
            state_next = S_RUN;
            timer_next = '0;
            retry_next = 4'd0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        S_RUN: begin
          // A loss of lock while running re-sequences without consuming a retry.
          if (!lk) begin
            state_next = S_RST;
            timer_next = '0;
            if (lost_reg != 8'hFF) lost_next = lost_reg + 8'd1;
          end
        end
        S_FAIL: begin
          state_next = S_FAIL;
        end
        default: begin
          state_next = S_RST;
          timer_next = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so the registered versions
    // change on the same edge as the state register.
    pll_rst_next = (state_next == S_RST) || (state_next == S_FAIL);
    sys_rst_next = (state_next != S_RUN);
    ready_next   = (state_next == S_RUN);
    fail_next    = (state_next == S_FAIL);
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_RST;
      timer_reg   <= '0;
      retry_reg   <= 4'd0;
      lost_reg    <= 8'd0;
      pll_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      fail_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      retry_reg   <= retry_next;
      lost_reg    <= lost_next;
      pll_rst_reg <= pll_rst_next;
      sys_rst_reg <= sys_rst_next;
      ready_reg   <= ready_next;
      fail_reg    <= fail_next;
    end
  end

  assign pll_rst_o   = pll_rst_reg;
  assign sys_rst_o   = sys_rst_reg;
  assign ready_o     = ready_reg;
  assign fail_o      = fail_reg;
  assign retry_cnt_o = retry_reg;
  assign lost_cnt_o  = lost_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: directed scenarios plus random lock
// activity, every cycle compared against a rule-based reference model.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 3;
  localparam int CNT_W         = 16;

  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       pll_rst_o, sys_rst_o, ready_o, fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lost_cnt_o;
  logic [2:0] state_o;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked_i(pll_locked_i),
    .restart_i   (restart_i),
    .pll_rst_o   (pll_rst_o),
    .sys_rst_o   (sys_rst_o),
    .ready_o     (ready_o),
    .fail_o      (fail_o),
    .retry_cnt_o (retry_cnt_o),
    .lost_cnt_o  (lost_cnt_o),
    .state_o     (state_o)
  );

  always #5 refclk = ~refclk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: phase, cycles spent in it, counters, and the lock
  // history seen through a two-cycle delay line.
  int m_phase, m_cyc, m_retry, m_lost;
  bit lk_q[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    m_phase = P_RST; m_cyc = 0; m_retry = 0; m_lost = 0;
    lk_q = '{1'b0, 1'b0};
  endfunction

  function automatic void enter(input int p);
    m_phase = p;
    m_cyc   = 0;
  endfunction

  function automatic void attempt_failed();
    m_retry++;
    enter((m_retry >= MAX_RETRY) ? P_FAIL : P_RST);
  endfunction

  function automatic void model_step();
    bit lk;
    lk = lk_q[0];
    void'(lk_q.pop_front());
    lk_q.push_back(pll_locked_i);
    if (restart_i) begin
      enter(P_RST);
      m_retry = 0;
    end else begin
      case (m_phase)
        P_RST:    if (m_cyc == RST_CYCLES - 1) enter(P_WAIT); else m_cyc++;
        P_WAIT:   if (lk) enter(P_STABLE);
                  else if (m_cyc == LOCK_TIMEOUT - 1) attempt_failed();
                  else m_cyc++;
        P_STABLE: if (!lk) attempt_failed();
                  else if (m_cyc == STABLE_CYCLES - 1) begin enter(P_RUN); m_retry = 0; end
                  else m_cyc++;
        P_RUN:    if (!lk) begin enter(P_RST); if (m_lost < 255) m_lost++; end
        default:  ;
      endcase
    end
  endfunction

  task automatic compare_all();
    int e;
    e = ((m_phase == P_RST || m_phase == P_FAIL) ? 8 : 0) + ((m_phase != P_RUN) ? 4 : 0)
      + ((m_phase == P_RUN) ? 2 : 0) + ((m_phase == P_FAIL) ? 1 : 0);
    check_eq("state", int'(state_o), m_phase);
    check_eq("ctrl", int'({pll_rst_o, sys_rst_o, ready_o, fail_o}), e);
    check_eq("retry", int'(retry_cnt_o), m_retry);
    check_eq("lost", int'(lost_cnt_o), m_lost);
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst) model_reset(); else model_step();
    #1;
    compare_all();
  endtask

  task automatic apply_reset(input bit lock_val);
    rst = 1'b1; pll_locked_i = lock_val; restart_i = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, fall, run_left;
    bit lv;
    model_reset();

    // Scenario 1: constant lock from reset release.
    apply_reset(1'b1);
    n = 0; fall = 0;
    while (!ready_o && n < 100) begin
      tick(); n++;
      if (!pll_rst_o && fall == 0) fall = n;
    end
    check_eq("s1_pll_rst_len", fall, RST_CYCLES);
    check_eq("s1_ready_after_rel", n, RST_CYCLES + 1 + STABLE_CYCLES);
    check_eq("s1_sys_rst", int'(sys_rst_o), 0);
    $display("scenario 1: lock from reset, ready after %0d cycles", n);

    // Scenario 4: lock drops in RUN for 5 cycles.
    pll_locked_i = 1'b0;
    n = 0;
    while (!sys_rst_o && n < 20) begin tick(); n++; end
    check_eq("s4_sys_rst_delay", n, 3);
    check_eq("s4_lost", int'(lost_cnt_o), 1);
    check_eq("s4_retry", int'(retry_cnt_o), 0);
    repeat (2) tick();
    pll_locked_i = 1'b1;
    $display("scenario 4: lock loss in RUN seen after %0d cycles", n);

    // Scenario 6: asynchronous reset in the middle of STABLE.
    n = 0;
    while (m_phase != P_STABLE && n < 100) begin tick(); n++; end
    check_eq("s6_reach_stable", int'(state_o), P_STABLE);
    #2 rst = 1'b1;
    #1;
    check_eq("s6_async_ctrl", int'({pll_rst_o, sys_rst_o, ready_o, fail_o}), 12);
    check_eq("s6_async_state", int'(state_o), P_RST);
    check_eq("s6_async_lost", int'(lost_cnt_o), 0);
    model_reset();
    $display("scenario 6: async reset in STABLE");

    // Scenario 2: no lock ever, retries exhausted, then restart.
    apply_reset(1'b0);
    n = 0;
    while (!fail_o && n < 300) begin tick(); n++; end
    check_eq("s2_fail", int'(fail_o), 1);
    check_eq("s2_retry", int'(retry_cnt_o), MAX_RETRY);
    repeat (10) tick();
    check_eq("s2_fail_held", int'({pll_rst_o, fail_o}), 3);
    restart_i = 1'b1; tick(); restart_i = 1'b0;
    check_eq("s2_restart_retry", int'(retry_cnt_o), 0);
    check_eq("s2_restart_fail", int'(fail_o), 0);
    n = 0;
    do begin tick(); n++; end while (pll_rst_o && n < 50);
    check_eq("s2_new_pll_rst_len", n, RST_CYCLES);
    $display("scenario 2: retries exhausted and restarted");

    // Scenario 5: restart coincides with the final lock timeout.
    apply_reset(1'b0);
    n = 0;
    while (!(m_phase == P_WAIT && m_cyc == LOCK_TIMEOUT - 1 && m_retry == MAX_RETRY - 1)
           && n < 300) begin tick(); n++; end
    check_eq("s5_reach_timeout", int'(retry_cnt_o), MAX_RETRY - 1);
    restart_i = 1'b1; tick(); restart_i = 1'b0;
    check_eq("s5_state", int'(state_o), P_RST);
    check_eq("s5_retry", int'(retry_cnt_o), 0);
    check_eq("s5_fail", int'(fail_o), 0);
    $display("scenario 5: restart on timeout cycle");

    // Scenario 3: lock drops on the last stable cycle, then a clean lock.
    apply_reset(1'b1);
    n = 0;
    while (!(m_phase == P_STABLE && m_cyc == STABLE_CYCLES - 3) && n < 100) begin tick(); n++; end
    pll_locked_i = 1'b0;
    n = 0;
    while (state_o != 3'(P_RST) && n < 10) begin tick(); n++; end
    check_eq("s3_back_to_rst", int'(state_o), P_RST);
    check_eq("s3_retry", int'(retry_cnt_o), 1);
    pll_locked_i = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin tick(); n++; end
    check_eq("s3_ready", int'(ready_o), 1);
    check_eq("s3_retry_cleared", int'(retry_cnt_o), 0);
    $display("scenario 3: late lock drop then clean lock");

    // Random lock activity with occasional restarts.
    apply_reset(1'b0);
    run_left = 0; lv = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        lv = ($urandom_range(0, 3) != 0);
        run_left = lv ? $urandom_range(1, 60) : $urandom_range(1, 30);
      end
      pll_locked_i = lv;
      restart_i = ($urandom_range(0, 149) == 0);
      run_left--;
      tick();
    end
    restart_i = 1'b0;
    $display("random: 4000 cycles, lost_cnt=%0d", lost_cnt_o);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
